apb_regfile_ws: RTL and testbench
=================================

# apb_regfile_ws

Parametrised APB3 slave register file. Successor of the fixed four-register APB_BUS: register count, data width and address width are parameters, and it adds programmable wait states, PREADY/PSLVERR and a busy interlock. It sits between the APB interconnect and the ECC encode/decode core, holding CTRL, DATA_IN, CODEWORD_WIDTH, NOISE and further configuration words, and pulses start to launch the core.

## Interface
- AMBA_WORD, 32, data width in bits (multiple of 8)
- AMBA_ADDR_WIDTH, 20, byte address width
- NUM_REGS, 4, number of read/write registers (2..16); index 0 = CTRL, 1 = DATA_IN, 2 = CODEWORD_WIDTH, 3 = NOISE
- WAIT_STATES, 0, access-phase wait cycles before PREADY (0..15)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- PADDR  in  AMBA_ADDR_WIDTH  byte address
- PSEL  in  1  slave select
- PENABLE  in  1  access phase
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  AMBA_WORD  write data
- PRDATA  out  AMBA_WORD  read data
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  error response, valid with PREADY
- busy  in  1  core busy; blocks writes
- regs  out  NUM_REGS*AMBA_WORD  register contents, reg i at bits [i*AMBA_WORD +: AMBA_WORD]
- start  out  1  one-cycle launch pulse

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE -> SETUP on PSEL=1, PENABLE=0. SETUP -> ACCESS unconditionally. ACCESS -> IDLE on PREADY=1 (back-to-back: ACCESS -> SETUP if PSEL=1 and PENABLE=0 in that same cycle is not legal APB; next SETUP is taken from IDLE).
- Wait counter cleared in SETUP, increments each ACCESS cycle with PREADY=0.
- Decode: index = PADDR[AMBA_ADDR_WIDTH-1:2]. Error if PADDR[1:0]!=0, index>=NUM_REGS, or (PWRITE=1 and busy=1).
- Write commits at the edge where PSEL&PENABLE&PREADY and no error; register takes PWDATA the following cycle. Error writes change nothing.
- Read: PRDATA = regs[index] while in ACCESS with PREADY=1 and no error; 0 otherwise (including error reads).
- start: registered; 1 in the cycle after a committed write to index 0 with PWDATA[0]=1; else 0. CTRL stores full PWDATA (bit 0 not self-clearing).
- busy sampled in the completing ACCESS cycle only.

## Timing
- Reset: all registers 0, FSM IDLE, counter 0, PRDATA 0, PREADY 0, PSLVERR 0, start 0.
- PREADY = (state==ACCESS) && (counter==WAIT_STATES), combinational decode of registered state; PSLVERR = PREADY && error.
- WAIT_STATES=0: transfer is SETUP + 1 ACCESS = 2 cycles; general = 2+WAIT_STATES cycles.
- Register write visible on regs and to a following read one cycle after the commit edge; start rises on that same cycle.
- PSEL dropped mid-ACCESS (protocol violation): FSM returns to IDLE, no commit.
- rst asserted mid-transfer: transfer abandoned, no commit, all outputs to reset values next edge.

## Structure
- Package apb_regfile_pkg: state enum (IDLE, SETUP, ACCESS), register index constants (CTRL_IDX=0, DATA_IN_IDX=1, CW_WIDTH_IDX=2, NOISE_IDX=3), CTRL_START_BIT=0.
- One sub-module: apb_wait_ctrl (FSM + wait counter, outputs state and PREADY); decode, register array and start logic in top.

## Test plan
- WAIT_STATES=0: write 0x0000_00A5 to 0x04, read 0x04 -> PREADY in 2nd cycle each, PRDATA=0xA5, PSLVERR=0.
- WAIT_STATES=3: write 0x1234 to 0x08 -> PREADY high exactly in 4th ACCESS cycle, regs[2]=0x1234 one cycle later.
- Write 0x1 to 0x00 with busy=0 -> start high one cycle after commit, then 0; write 0x0 -> no start.
- busy=1, write 0x1 to 0x00 -> PSLVERR=1, CTRL unchanged, no start; read 0x00 under busy=1 -> PSLVERR=0.
- Access 0x10 with NUM_REGS=4 and 0x06 misaligned -> PSLVERR=1, PRDATA=0, no register change.
- rst pulsed during ACCESS of write 0xFFFF to 0x0C -> regs[3]=0, PREADY=0, start=0 after reset.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : apb_regfile_pkg
//  Description : Shared types and constants for the APB wait-state register
//                file: bus FSM state encoding, register index map and the
//                CTRL start bit position.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_regfile_pkg;

    // Bus-phase state of the APB slave FSM
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    // Register index map
    localparam int CTRL_IDX       = 0;
    localparam int DATA_IN_IDX    = 1;
    localparam int CW_WIDTH_IDX   = 2;
    localparam int NOISE_IDX      = 3;

    // Bit of CTRL that launches the core when written as 1
    localparam int CTRL_START_BIT = 0;

    // Width of the access-phase wait counter (WAIT_STATES is 0..15)
    localparam int WAIT_CNT_W     = 4;

    // A register access must be word aligned
    function automatic logic addr_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/apb_regfile_ws_if.sv
`default_nettype none
// ============================================================================
//  Module      : apb_regfile_ws_if
//  Description : APB3 bus bundle between the interconnect (master) and the
//                register file (slave).
//                Ports: PADDR, PSEL, PENABLE, PWRITE, PWDATA (master -> slave)
//                       PRDATA, PREADY, PSLVERR        (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface apb_regfile_ws_if #(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20
);
    logic [AMBA_ADDR_WIDTH-1:0] PADDR;
    logic                       PSEL;
    logic                       PENABLE;
    logic                       PWRITE;
    logic [AMBA_WORD-1:0]       PWDATA;
    logic [AMBA_WORD-1:0]       PRDATA;
    logic                       PREADY;
    logic                       PSLVERR;

    modport master (
        output PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PADDR, PSEL, PENABLE, PWRITE, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface
`default_nettype wire

// File: rtl/apb_wait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : apb_wait_ctrl
//  Description : APB slave phase FSM with programmable access-phase wait
//                counter. PREADY rises once the transfer has spent
//                WAIT_STATES cycles in ACCESS.
//                Ports: clk, rst     - clock, synchronous active-high reset
//                       psel_i       - slave select
//                       penable_i    - access phase strobe
//                       state_o      - current bus phase
//                       pready_o     - transfer completes this cycle
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_ctrl
    import apb_regfile_pkg::*;
#(
    parameter int WAIT_STATES = 0
) (
    input  wire        clk,
    input  wire        rst,
    input  wire        psel_i,
    input  wire        penable_i,
    output apb_state_e state_o,
    output logic       pready_o
);

    localparam logic [WAIT_CNT_W-1:0] C_WAIT = WAIT_CNT_W'(WAIT_STATES);

    apb_state_e              state_q;
    logic [WAIT_CNT_W-1:0]   cnt_q;

    // The bus setup phase is the cycle in which PSEL is seen with PENABLE
    // low. It is recognised directly from the bus so the registered state is
    // already ACCESS on the first PENABLE cycle; this gives the two-cycle
    // zero-wait transfer. SETUP as a registered state only falls through.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (psel_i && !penable_i) begin
                        state_q <= ACCESS;
                        cnt_q   <= '0;
                    end
                end
                SETUP: begin
                    state_q <= ACCESS;
                    cnt_q   <= '0;
                end
                ACCESS: begin
                    // Completion or a dropped PSEL both end the transfer;
                    // a new transfer always restarts from IDLE.
                    if (!psel_i || pready_o) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign pready_o = (state_q == ACCESS) && (cnt_q == C_WAIT);

    // Report the bus phase, including the setup cycle seen from IDLE
    assign state_o  = (state_q == IDLE && psel_i && !penable_i) ? SETUP : state_q;

endmodule
`default_nettype wire

// File: rtl/apb_regfile_ws.sv
`default_nettype none
// ============================================================================
//  Module      : apb_regfile_ws
//  Description : Parametrised APB3 slave register file with wait states,
//                error response and busy interlock. Holds the ECC core
//                configuration words and pulses start when CTRL bit 0 is
//                written as 1.
//                Ports: clk, rst - clock, synchronous active-high reset
//                       apb      - APB3 slave bus bundle
//                       busy     - core busy, blocks writes
//                       regs     - flattened register contents
//                       start    - one-cycle launch pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_regfile_ws
    import apb_regfile_pkg::*;
#(
    parameter int AMBA_WORD       = 32,
    parameter int AMBA_ADDR_WIDTH = 20,
    parameter int NUM_REGS        = 4,
    parameter int WAIT_STATES     = 0
) (
    input  wire                            clk,
    input  wire                            rst,
    apb_regfile_ws_if.slave                apb,
    input  wire                            busy,
    output logic [NUM_REGS*AMBA_WORD-1:0]  regs,
    output logic                           start
);

    localparam int IDX_W = AMBA_ADDR_WIDTH - 2;

    apb_state_e             w_state;
    logic                   w_pready;
    logic [IDX_W-1:0]       w_idx;
    logic                   w_idx_ok;
    logic                   w_err;
    logic                   w_commit;
    logic                   w_start_d;
    logic [AMBA_WORD-1:0]   w_rd_mux;

    logic [AMBA_WORD-1:0]   regs_q [NUM_REGS];
    logic                   start_q;

    apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait_ctrl (
        .clk       (clk),
        .rst       (rst),
        .psel_i    (apb.PSEL),
        .penable_i (apb.PENABLE),
        .state_o   (w_state),
        .pready_o  (w_pready)
    );

    // ---------------------------------------------------------------- decode
    assign w_idx    = apb.PADDR[AMBA_ADDR_WIDTH-1:2];
    assign w_idx_ok = (32'(w_idx) < 32'(NUM_REGS));
    // busy only matters in the completing cycle, where w_err is consumed
    assign w_err    = addr_misaligned(apb.PADDR[1:0]) || !w_idx_ok ||
                      (apb.PWRITE && busy);
    assign w_commit = apb.PSEL && apb.PENABLE && w_pready && !w_err && apb.PWRITE;

    // -------------------------------------------------------- register array
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        always_ff @(posedge clk) begin
            if (rst) begin
                regs_q[i] <= '0;
            end else if (w_commit && (w_idx == IDX_W'(i))) begin
                regs_q[i] <= apb.PWDATA;
            end
        end
        assign regs[i*AMBA_WORD +: AMBA_WORD] = regs_q[i];
    end

    // ----------------------------------------------------------- read path
    always_comb begin
        w_rd_mux = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_idx == IDX_W'(i)) begin
                w_rd_mux = regs_q[i];
            end
        end
    end

    assign apb.PRDATA  = ((w_state == ACCESS) && w_pready && !w_err) ? w_rd_mux : '0;
    assign apb.PREADY  = w_pready;
    assign apb.PSLVERR = w_pready && w_err;

    // ---------------------------------------------------------- start pulse
    assign w_start_d = w_commit && (w_idx == IDX_W'(CTRL_IDX)) &&
                       apb.PWDATA[CTRL_START_BIT];

    always_ff @(posedge clk) begin
        if (rst) begin
            start_q <= 1'b0;
        end else begin
            start_q <= w_start_d;
        end
    end

    assign start = start_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_regfile_ws.sv
`default_nettype none
// ============================================================================
//  Module      : tb_apb_regfile_ws
//  Description : Self-checking bench for apb_regfile_ws. Two instances
//                (WAIT_STATES 0 and 3) share one driven bus; PSEL is steered
//                to one of them per transfer. A transaction-level model
//                predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_regfile_ws;

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] paddr;
    logic        psel, penable, pwrite, busy;
    logic [31:0] pwdata;
    int          sel;

    logic [127:0] regs_w  [2];
    logic         start_w [2];
    logic         pready_w[2];
    logic         pslverr_w[2];
    logic [31:0]  prdata_w[2];

    apb_regfile_ws_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) bus0 ();
    apb_regfile_ws_if #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20)) bus1 ();

    assign bus0.PADDR   = paddr;
    assign bus0.PSEL    = psel && (sel == 0);
    assign bus0.PENABLE = penable;
    assign bus0.PWRITE  = pwrite;
    assign bus0.PWDATA  = pwdata;
    assign bus1.PADDR   = paddr;
    assign bus1.PSEL    = psel && (sel == 1);
    assign bus1.PENABLE = penable;
    assign bus1.PWRITE  = pwrite;
    assign bus1.PWDATA  = pwdata;

    assign pready_w[0]  = bus0.PREADY;
    assign pready_w[1]  = bus1.PREADY;
    assign pslverr_w[0] = bus0.PSLVERR;
    assign pslverr_w[1] = bus1.PSLVERR;
    assign prdata_w[0]  = bus0.PRDATA;
    assign prdata_w[1]  = bus1.PRDATA;

    apb_regfile_ws #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .NUM_REGS(4), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .apb(bus0), .busy(busy), .regs(regs_w[0]), .start(start_w[0])
    );
    apb_regfile_ws #(.AMBA_WORD(32), .AMBA_ADDR_WIDTH(20), .NUM_REGS(4), .WAIT_STATES(3)) dut1 (
        .clk(clk), .rst(rst), .apb(bus1), .busy(busy), .regs(regs_w[1]), .start(start_w[1])
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------ model
    logic [31:0] m_regs   [2][4];
    logic        exp_pready [2];
    logic        exp_pslverr[2];
    logic [31:0] exp_prdata [2];
    logic        exp_start  [2];
    logic        pend_wr    [2];
    int          pend_idx   [2];
    logic [31:0] pend_data  [2];
    logic        pend_start [2];
    logic        chk_en;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_vec(input int d);
        return {m_regs[d][3], m_regs[d][2], m_regs[d][1], m_regs[d][0]};
    endfunction

    // Advance one clock; apply what the closing edge committed
    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int r = 0; r < 4; r++) m_regs[d][r] = '0;
                pend_wr[d]    = 1'b0;
                pend_start[d] = 1'b0;
            end
            if (pend_wr[d]) m_regs[d][pend_idx[d]] = pend_data[d];
            exp_start[d]   = pend_start[d];
            pend_wr[d]     = 1'b0;
            pend_start[d]  = 1'b0;
            exp_pready[d]  = 1'b0;
            exp_pslverr[d] = 1'b0;
            exp_prdata[d]  = '0;
        end
    endtask

    // Whole-transfer model: SETUP, then WS+1 ACCESS cycles, then one idle
    task automatic xfer(input int d, input logic [19:0] a, input logic wr,
                        input logic [31:0] data, input logic bsy,
                        output logic [31:0] rd, output logic err_o);
        int   w   = (d == 1) ? 3 : 0;
        int   idx = int'(a[19:2]);
        logic err = (a[1:0] != 2'b00) || (idx >= 4) || (wr && bsy);
        rd    = '0;
        err_o = 1'b0;
        tick();
        sel = d; psel = 1'b1; penable = 1'b0;
        paddr = a; pwrite = wr; pwdata = data; busy = bsy;
        for (int k = 0; k <= w; k++) begin
            tick();
            penable = 1'b1;
            if (k == w) begin
                exp_pready[d]  = 1'b1;
                exp_pslverr[d] = err;
                if (!err) exp_prdata[d] = m_regs[d][idx];
            end
            @(negedge clk);
            if (k == w) begin
                rd    = prdata_w[d];
                err_o = pslverr_w[d];
            end
        end
        if (!err && wr) begin
            pend_wr[d]    = 1'b1;
            pend_idx[d]   = idx;
            pend_data[d]  = data;
            pend_start[d] = (idx == 0) && data[0];
        end
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        busy = ($urandom_range(0, 1) == 1);
    endtask

    // ---------------------------------------------------- compare process
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("d%0d PREADY", d),  128'(pready_w[d]),  128'(exp_pready[d]));
                check($sformatf("d%0d PSLVERR", d), 128'(pslverr_w[d]), 128'(exp_pslverr[d]));
                check($sformatf("d%0d PRDATA", d),  128'(prdata_w[d]),  128'(exp_prdata[d]));
                check($sformatf("d%0d start", d),   128'(start_w[d]),   128'(exp_start[d]));
                check($sformatf("d%0d regs", d),    regs_w[d],          model_vec(d));
            end
        end
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        logic [31:0] rd;
        logic        e;
        logic [19:0] a;

        chk_en = 1'b0;
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; busy = 1'b0; sel = 0;
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 4; r++) m_regs[d][r] = '0;
            pend_wr[d] = 1'b0; pend_start[d] = 1'b0; pend_idx[d] = 0; pend_data[d] = '0;
            exp_pready[d] = 1'b0; exp_pslverr[d] = 1'b0; exp_prdata[d] = '0; exp_start[d] = 1'b0;
        end
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        // zero wait states: write then read DATA_IN
        xfer(0, 20'h00004, 1'b1, 32'h0000_00A5, 1'b0, rd, e);
        check("ws0 write pslverr", 128'(e), 128'(0));
        xfer(0, 20'h00004, 1'b0, 32'h0, 1'b0, rd, e);
        check("ws0 read prdata", 128'(rd), 128'h0000_00A5);
        check("ws0 read pslverr", 128'(e), 128'(0));

        // three wait states: CODEWORD_WIDTH visible right after the commit
        xfer(1, 20'h00008, 1'b1, 32'h0000_1234, 1'b0, rd, e);
        @(negedge clk);
        check("ws3 regs[2]", 128'(regs_w[1][95:64]), 128'h1234);

        // start pulse on CTRL bit 0
        xfer(0, 20'h00000, 1'b1, 32'h1, 1'b0, rd, e);
        @(negedge clk);
        check("start pulse high", 128'(start_w[0]), 128'(1));
        tick();
        @(negedge clk);
        check("start pulse low", 128'(start_w[0]), 128'(0));
        xfer(0, 20'h00000, 1'b1, 32'h0, 1'b0, rd, e);
        @(negedge clk);
        check("no start on 0", 128'(start_w[0]), 128'(0));

        // busy interlock
        xfer(0, 20'h00000, 1'b1, 32'h1, 1'b1, rd, e);
        check("busy write pslverr", 128'(e), 128'(1));
        @(negedge clk);
        check("busy write no start", 128'(start_w[0]), 128'(0));
        check("busy write CTRL", 128'(regs_w[0][31:0]), 128'(0));
        xfer(0, 20'h00000, 1'b0, 32'h0, 1'b1, rd, e);
        check("busy read pslverr", 128'(e), 128'(0));

        // out-of-range and misaligned
        xfer(0, 20'h00010, 1'b0, 32'h0, 1'b0, rd, e);
        check("oor pslverr", 128'(e), 128'(1));
        check("oor prdata", 128'(rd), 128'(0));
        xfer(1, 20'h00006, 1'b1, 32'hDEAD_BEEF, 1'b0, rd, e);
        check("misaligned pslverr", 128'(e), 128'(1));
        xfer(0, 20'h00006, 1'b0, 32'h0, 1'b0, rd, e);
        check("misaligned rd pslverr", 128'(e), 128'(1));
        check("misaligned prdata", 128'(rd), 128'(0));

        // PSEL dropped mid-ACCESS on the wait-state instance: no commit
        tick();
        sel = 1; psel = 1'b1; penable = 1'b0; paddr = 20'h00004; pwrite = 1'b1;
        pwdata = 32'h5555_AAAA; busy = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        psel = 1'b0; penable = 1'b0;
        tick();
        tick();
        @(negedge clk);
        check("psel drop no commit", 128'(regs_w[1][63:32]), 128'(0));

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            int d = $urandom_range(0, 1);
            a = 20'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 7) == 0) a = a | 20'($urandom_range(1, 3));
            if ($urandom_range(0, 15) == 0) a = 20'($urandom_range(0, 20'hFFFFF));
            xfer(d, a, ($urandom_range(0, 1) == 1), $urandom(),
                 ($urandom_range(0, 3) == 0), rd, e);
            if ($urandom_range(0, 3) == 0) tick();
        end

        // reset during ACCESS of a NOISE write on the wait-state instance
        xfer(1, 20'h0000C, 1'b1, 32'h0000_ABCD, 1'b0, rd, e);
        tick();
        sel = 1; psel = 1'b1; penable = 1'b0; paddr = 20'h0000C; pwrite = 1'b1;
        pwdata = 32'h0000_FFFF; busy = 1'b0;
        tick();
        penable = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        check("rst regs[3]", 128'(regs_w[1][127:96]), 128'(0));
        check("rst PREADY", 128'(pready_w[1]), 128'(0));
        check("rst start", 128'(start_w[1]), 128'(0));
        tick();
        tick();

        // post-reset sanity transfer
        xfer(1, 20'h0000C, 1'b1, 32'h0000_0F0F, 1'b0, rd, e);
        xfer(1, 20'h0000C, 1'b0, 32'h0, 1'b0, rd, e);
        check("post rst readback", 128'(rd), 128'h0F0F);
        tick();

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
